// File: rtl/systolic_in_buff_mc_pkg.sv
// ============================================================================
// Module      : sysin_pkg
// Description : Shared sizing helpers and types for the multi-channel
//               systolic input staging buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sysin_pkg;

    localparam int c_MAX_DEPTH_LOG2 = 16;

    // Wide enough for the occupancy count of any supported channel depth
    typedef logic [c_MAX_DEPTH_LOG2:0] cnt_t;

    function automatic int ch_w(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

    function automatic int depth_of(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_in_buff_mc_if.sv
// ============================================================================
// Module      : systolic_in_buff_mc_if
// Description : Tagged DMA write stream plus per-channel valid/ready read
//               ports. Optional macro SYSIN_FLUSH_EN adds per-channel flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface systolic_in_buff_mc_if
    import sysin_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int DMA_DATA_WIDTH = 32
) ();

    localparam int c_CH_W = ch_w(NUM_CH);

    logic                               in_valid;
    logic                               in_ready;
    logic [c_CH_W-1:0]                  in_ch;
    logic [DMA_DATA_WIDTH-1:0]          in_data;
    logic [NUM_CH-1:0]                  out_valid;
    logic [NUM_CH-1:0]                  out_ready;
    logic [NUM_CH*DMA_DATA_WIDTH-1:0]   out_data;
    logic                               ch_err;
`ifdef SYSIN_FLUSH_EN
    logic [NUM_CH-1:0]                  flush;

    modport master (
        output in_valid, in_ch, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, ch_err
    );
    modport slave (
        input  in_valid, in_ch, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, ch_err
    );
`else
    modport master (
        output in_valid, in_ch, in_data, out_ready,
        input  in_ready, out_valid, out_data, ch_err
    );
    modport slave (
        input  in_valid, in_ch, in_data, out_ready,
        output in_ready, out_valid, out_data, ch_err
    );
`endif

endinterface

`default_nettype wire

// File: rtl/systolic_in_buff_mc_ch_fifo.sv
// ============================================================================
// Module      : sysin_ch_fifo
// Description : One first-word-fall-through channel: simple dual-port memory,
//               registered read stage and output register. Optional macro
//               SYSIN_FLUSH_EN adds a synchronous flush input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sysin_ch_fifo
    import sysin_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  wire                 clk,
    input  wire                 rst,
    input  wire                 wr_en,
    input  wire  [DATA_W-1:0]   wr_data,
`ifdef SYSIN_FLUSH_EN
    input  wire                 flush,
`endif
    output logic                full,
    output logic                out_valid,
    input  wire                 out_ready,
    output logic [DATA_W-1:0]   out_data
);

    localparam int c_DEPTH = depth_of(DEPTH_LOG2);

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   ch_cnt_t;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_out_data;
    ptr_t              r_wr_ptr;
    ptr_t              r_rd_ptr;
    ch_cnt_t           r_cnt;
    logic              r_rd_pend;
    logic              r_out_valid;

    logic              w_flush;
    logic              w_pop;
    logic              w_load;
    logic              w_rd_en;
    ch_cnt_t           w_mem_cnt;

`ifdef SYSIN_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // cnt covers memory, the in-flight read and the output register alike
    assign w_pop     = r_out_valid && out_ready;
    assign w_load    = r_rd_pend && (!r_out_valid || w_pop);
    assign w_mem_cnt = r_cnt - ch_cnt_t'(r_out_valid) - ch_cnt_t'(r_rd_pend);
    assign w_rd_en   = (w_mem_cnt != '0) && (!r_rd_pend || w_load);

    assign full      = (cnt_t'(r_cnt) == cnt_t'(c_DEPTH));
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    always_ff @(posedge clk) begin
        if (!rst || w_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_rd_pend   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (wr_en)
                r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            if (w_rd_en)
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            r_cnt <= r_cnt + ch_cnt_t'(wr_en) - ch_cnt_t'(w_pop);
            if (w_rd_en)
                r_rd_pend <= 1'b1;
            else if (w_load)
                r_rd_pend <= 1'b0;
            if (w_load)
                r_out_valid <= 1'b1;
            else if (w_pop)
                r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            r_mem[r_wr_ptr] <= wr_data;
        if (w_rd_en)
            r_rd_data <= r_mem[r_rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (w_load)
            r_out_data <= r_rd_data;
    end

endmodule

`default_nettype wire

// File: rtl/systolic_in_buff_mc.sv
// ============================================================================
// Module      : systolic_in_buff_mc
// Description : Multi-channel input staging buffer between the DMA write
//               stream and the systolic array edges. Optional macro
//               SYSIN_FLUSH_EN enables per-channel flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_in_buff_mc
    import sysin_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int DMA_DATA_WIDTH = 32,
    parameter int DEPTH_LOG2     = 5
) (
    input  wire                     clk,
    input  wire                     rst,
    systolic_in_buff_mc_if.slave    bus
);

    logic [NUM_CH-1:0]                  w_full;
    logic [NUM_CH-1:0]                  w_flush;
    logic [NUM_CH-1:0]                  w_wr_en;
    logic [NUM_CH-1:0]                  w_out_valid;
    logic [NUM_CH*DMA_DATA_WIDTH-1:0]   w_out_data;
    logic                               w_bad_tag;
    logic                               w_sel_blocked;
    logic                               w_in_ready;
    logic                               r_ch_err;

`ifdef SYSIN_FLUSH_EN
    assign w_flush = bus.flush;
`else
    assign w_flush = '0;
`endif

    assign w_bad_tag = (32'(bus.in_ch) >= 32'(NUM_CH));

    // Only registered state feeds in_ready, so a same-cycle pop never frees a slot
    always_comb begin
        w_sel_blocked = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (32'(bus.in_ch) == c)
                w_sel_blocked = w_full[c] || w_flush[c];
        end
    end

    assign w_in_ready    = rst && (w_bad_tag || !w_sel_blocked);
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.ch_err    = r_ch_err;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            assign w_wr_en[c] = bus.in_valid && w_in_ready && !w_bad_tag
                                && (32'(bus.in_ch) == 32'(c));

            sysin_ch_fifo #(
                .DATA_W     (DMA_DATA_WIDTH),
                .DEPTH_LOG2 (DEPTH_LOG2)
            ) u_fifo (
                .clk        (clk),
                .rst        (rst),
                .wr_en      (w_wr_en[c]),
                .wr_data    (bus.in_data),
`ifdef SYSIN_FLUSH_EN
                .flush      (w_flush[c]),
`endif
                .full       (w_full[c]),
                .out_valid  (w_out_valid[c]),
                .out_ready  (bus.out_ready[c]),
                .out_data   (w_out_data[c*DMA_DATA_WIDTH +: DMA_DATA_WIDTH])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst)
            r_ch_err <= 1'b0;
        else if (bus.in_valid && w_bad_tag)
            r_ch_err <= 1'b1;
    end

endmodule

`default_nettype wire

// File: tb/tb_systolic_in_buff_mc.sv
// ============================================================================
// Module      : tb_systolic_in_buff_mc
// Description : Self-checking bench for systolic_in_buff_mc (NUM_CH=3 so a
//               bad tag is reachable). Honours SYSIN_FLUSH_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_in_buff_mc;

    localparam int NUM_CH = 3;
    localparam int W      = 32;
    localparam int DL2    = 5;
    localparam int DEPTH  = 32;
    localparam int RB     = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    systolic_in_buff_mc_if #(.NUM_CH(NUM_CH), .DMA_DATA_WIDTH(W)) bus ();

    systolic_in_buff_mc #(
        .NUM_CH         (NUM_CH),
        .DMA_DATA_WIDTH (W),
        .DEPTH_LOG2     (DL2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one circular queue of accepted beats per channel
    logic [W-1:0]      m_q [NUM_CH][RB];
    int                m_head [NUM_CH];
    int                m_cnt  [NUM_CH];
    logic              m_err;
    logic [NUM_CH-1:0] m_stall;
    int                n_acc;

    typedef struct packed {
        logic              v;
        logic [1:0]        ch;
        logic [W-1:0]      d;
        logic [NUM_CH-1:0] ordy;
        logic              e_rdy;
        logic [NUM_CH-1:0] e_ov;
        logic [NUM_CH*W-1:0] e_data;
        logic              e_err;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int ch, input logic [W-1:0] d,
                         input logic [NUM_CH-1:0] ordy);
        bus.in_valid  = v;
        bus.in_ch     = ch[1:0];
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    task automatic at_sample();
        logic exp_rdy;
        logic bad;
        logic fl;
        int   ch;
        @(negedge clk);
        ch  = int'(bus.in_ch);
        bad = (ch >= NUM_CH);
        exp_rdy = 1'b0;
        if (rst)
            exp_rdy = bad ? 1'b1 : (m_cnt[ch] < DEPTH);
`ifdef SYSIN_FLUSH_EN
        if (!bad && bus.flush[ch]) exp_rdy = 1'b0;
`endif
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("ch_err", 32'(bus.ch_err), 32'(m_err));
        for (int c = 0; c < NUM_CH; c++) begin
            if (m_stall[c]) chk("hold_valid", 32'(bus.out_valid[c]), 32'd1);
            if (bus.out_valid[c]) begin
                if (m_cnt[c] == 0) chk("valid_when_empty", 32'(bus.out_valid[c]), 32'd0);
                else chk("out_data", bus.out_data[c*W +: W], m_q[c][m_head[c]]);
            end
        end
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_cnt[c]  = 0;
                m_head[c] = 0;
            end
            m_err   = 1'b0;
            m_stall = '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                fl = 1'b0;
`ifdef SYSIN_FLUSH_EN
                fl = bus.flush[c];
`endif
                if (fl) begin
                    m_cnt[c]   = 0;
                    m_head[c]  = 0;
                    m_stall[c] = 1'b0;
                end else begin
                    if (bus.out_valid[c] && bus.out_ready[c] && m_cnt[c] > 0) begin
                        m_head[c] = (m_head[c] + 1) % RB;
                        m_cnt[c]--;
                    end
                    if (bus.in_valid && exp_rdy && !bad && ch == c) begin
                        m_q[c][(m_head[c] + m_cnt[c]) % RB] = bus.in_data;
                        m_cnt[c]++;
                        n_acc++;
                    end
                    m_stall[c] = bus.out_valid[c] && !bus.out_ready[c];
                end
            end
            if (bus.in_valid && bad) m_err = 1'b1;
        end
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        at_sample();
        to_next();
    endtask

    task automatic do_reset();
        drive(1'b0, 0, '0, '0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int npops;
        int cyc;
        int r;
        int sel;
        int left;

        for (int c = 0; c < NUM_CH; c++) begin
            m_head[c] = 0;
            m_cnt[c]  = 0;
        end
        m_err   = 1'b0;
        m_stall = '0;
        n_acc   = 0;
        drive(1'b0, 0, '0, '0);
`ifdef SYSIN_FLUSH_EN
        bus.flush = '0;
`endif
        rst = 1'b0;
        repeat (2) to_next();
        tick();
        rst = 1'b1;

        // Latency, pop and bad-tag vectors: {v, ch, d, ordy, rdy, ov, data, err}
        tbl[0]  = '{1'b1, 2'd0, 32'hA5A5_0001, 3'b000, 1'b1, 3'b000, 96'h0, 1'b0};
        tbl[1]  = '{1'b0, 2'd0, 32'h0,         3'b000, 1'b1, 3'b000, 96'h0, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 32'h0,         3'b000, 1'b1, 3'b000, 96'h0, 1'b0};
        tbl[3]  = '{1'b0, 2'd0, 32'h0,         3'b000, 1'b1, 3'b001, {64'h0, 32'hA5A5_0001}, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 32'h0,         3'b001, 1'b1, 3'b001, {64'h0, 32'hA5A5_0001}, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 32'h0,         3'b000, 1'b1, 3'b000, 96'h0, 1'b0};
        tbl[6]  = '{1'b1, 2'd3, 32'hDEAD_BEEF, 3'b000, 1'b1, 3'b000, 96'h0, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 32'h0,         3'b000, 1'b1, 3'b000, 96'h0, 1'b1};
        tbl[8]  = '{1'b1, 2'd1, 32'h1234_5678, 3'b000, 1'b1, 3'b000, 96'h0, 1'b1};
        tbl[9]  = '{1'b0, 2'd0, 32'h0,         3'b000, 1'b1, 3'b000, 96'h0, 1'b1};
        tbl[10] = '{1'b0, 2'd0, 32'h0,         3'b000, 1'b1, 3'b000, 96'h0, 1'b1};
        tbl[11] = '{1'b0, 2'd0, 32'h0,         3'b010, 1'b1, 3'b010, {32'h0, 32'h1234_5678, 32'h0}, 1'b1};
        tbl[12] = '{1'b0, 2'd0, 32'h0,         3'b000, 1'b1, 3'b000, 96'h0, 1'b1};

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, int'(tbl[i].ch), tbl[i].d, tbl[i].ordy);
            at_sample();
            chk("vec_in_ready", 32'(bus.in_ready), 32'(tbl[i].e_rdy));
            chk("vec_out_valid", 32'(bus.out_valid), 32'(tbl[i].e_ov));
            chk("vec_ch_err", 32'(bus.ch_err), 32'(tbl[i].e_err));
            for (int c = 0; c < NUM_CH; c++)
                if (tbl[i].e_ov[c])
                    chk("vec_out_data", bus.out_data[c*W +: W], tbl[i].e_data[c*W +: W]);
            to_next();
        end

        // Fill ch1 to full, confirm ch0 still accepted, then drain at full rate
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1, 32'(i), 3'b000);
            at_sample();
            chk("fill_rdy", 32'(bus.in_ready), 32'd1);
            to_next();
        end
        drive(1'b1, 1, 32'h99, 3'b000);
        at_sample();
        chk("full_rdy", 32'(bus.in_ready), 32'd0);
        to_next();
        drive(1'b1, 0, 32'hC0, 3'b000);
        at_sample();
        chk("other_ch_rdy", 32'(bus.in_ready), 32'd1);
        to_next();
        drive(1'b0, 0, '0, 3'b010);
        for (int i = 0; i < DEPTH; i++) begin
            at_sample();
            chk("pop_valid", 32'(bus.out_valid[1]), 32'd1);
            chk("pop_data", bus.out_data[W +: W], 32'(i));
            to_next();
        end
        at_sample();
        chk("ch1_empty", 32'(bus.out_valid[1]), 32'd0);
        to_next();

        // Full channel: push coinciding with a pop is refused, accepted next cycle
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 0, 32'h100 + 32'(i), 3'b000);
            tick();
        end
        drive(1'b1, 0, 32'h200, 3'b001);
        at_sample();
        chk("full_pop_refuse", 32'(bus.in_ready), 32'd0);
        to_next();
        drive(1'b1, 0, 32'h200, 3'b000);
        at_sample();
        chk("after_pop_accept", 32'(bus.in_ready), 32'd1);
        to_next();
        drive(1'b1, 0, 32'h201, 3'b000);
        at_sample();
        chk("refull_rdy", 32'(bus.in_ready), 32'd0);
        to_next();
        drive(1'b0, 0, '0, 3'b001);
        npops = 0;
        for (int i = 0; i < 80 && m_cnt[0] > 0; i++) begin
            at_sample();
            if (bus.out_valid[0]) npops++;
            to_next();
        end
        chk("full_drain_count", 32'(npops), 32'(DEPTH));

        // Randomized interleaved traffic with random backpressure
        do_reset();
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 1000 && cyc < 20000) begin
            r   = int'($urandom_range(0, 99));
            sel = (r < 46) ? 0 : (r < 92) ? 1 : (r < 99) ? 2 : 3;
            drive($urandom_range(0, 3) != 0, sel, $urandom,
                  {$urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6});
            tick();
            cyc++;
        end
        chk("rand_accepted_1000", 32'(n_acc >= 1000), 32'd1);
        drive(1'b0, 0, '0, '1);
        cyc  = 0;
        left = m_cnt[0] + m_cnt[1] + m_cnt[2];
        while (left > 0 && cyc < 300) begin
            tick();
            cyc++;
            left = m_cnt[0] + m_cnt[1] + m_cnt[2];
        end
        chk("rand_drain_left", 32'(left), 32'd0);
        repeat (3) tick();
        chk("rand_idle_valid", 32'(bus.out_valid), 32'd0);

        // Reset with queued entries, then fresh write latency
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 0, 32'h300 + 32'(i), 3'b000);
            tick();
        end
        drive(1'b0, 0, '0, 3'b000);
        repeat (3) tick();
        rst = 1'b0;
        at_sample();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        to_next();
        rst = 1'b1;
        at_sample();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        to_next();
        drive(1'b1, 0, 32'h77, 3'b000);
        tick();
        drive(1'b0, 0, '0, 3'b000);
        at_sample();
        chk("post_rst_lat1", 32'(bus.out_valid[0]), 32'd0);
        to_next();
        at_sample();
        chk("post_rst_lat2", 32'(bus.out_valid[0]), 32'd0);
        to_next();
        at_sample();
        chk("post_rst_valid", 32'(bus.out_valid[0]), 32'd1);
        chk("post_rst_data", bus.out_data[0 +: W], 32'h77);
        to_next();

`ifdef SYSIN_FLUSH_EN
        // Flush discards queued beats and blocks a same-cycle push
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 0, 32'h400 + 32'(i), 3'b000);
            tick();
        end
        drive(1'b0, 0, '0, 3'b000);
        repeat (3) tick();
        bus.flush = 3'b001;
        drive(1'b1, 0, 32'h55, 3'b001);
        at_sample();
        chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
        to_next();
        bus.flush = '0;
        drive(1'b0, 0, '0, 3'b000);
        at_sample();
        chk("flush_out_valid", 32'(bus.out_valid[0]), 32'd0);
        to_next();
        repeat (3) tick();
        chk("flush_stays_empty", 32'(bus.out_valid[0]), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
